// File: rtl/entrada_dados_fila_pkg.sv
// Shared defaults and sizing helper for the data-entry capture FIFO.
package entrada_dados_fila_pkg;

  localparam int ENTRADA_WIDTH_DEFAULT = 18;
  localparam int ENTRADA_DEPTH_DEFAULT = 4;
  localparam int SYNC_STAGES_DEFAULT   = 2;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/entrada_dados_fila_sincronizador_borda.sv
// Button synchroniser with rising-edge detector; every flop resets high so a
// button held through reset must be released before it can produce an event.
module sincronizador_borda
  import entrada_dados_fila_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/entrada_dados_fila.sv
// Input-capture FIFO: `in` pushes the switch bus, `enter` pops the head entry.
module entrada_dados_fila
  import entrada_dados_fila_pkg::*;
#(
  parameter int WIDTH       = ENTRADA_WIDTH_DEFAULT,
  parameter int DEPTH       = ENTRADA_DEPTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               entrada,
  input  logic                           in,
  input  logic                           enter,
  output logic                           sinal,
  output logic [WIDTH-1:0]               valor,
  output logic [count_width(DEPTH)-1:0]  count,
  output logic                           full,
  output logic                           overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic             rise_in, rise_enter;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             empty_w, full_w, push_ok, pop_ok;

  sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sync_in (
    .clock   (clock),
    .reset   (reset),
    .async_i (in),
    .rise_o  (rise_in)
  );

  sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sync_enter (
    .clock   (clock),
    .reset   (reset),
    .async_i (enter),
    .rise_o  (rise_enter)
  );

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    empty_w    = (count_q == '0);
    full_w     = (count_q == CW'(DEPTH));
    pop_ok     = rise_enter & ~empty_w;
    push_ok    = rise_in & (~full_w | pop_ok);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (rise_in & full_w & ~pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= entrada;
  end

  assign sinal    = ~empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign valor    = empty_w ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_entrada_dados_fila.sv
// Directed bench: default instance plus a WIDTH=8/DEPTH=8/SYNC_STAGES=3 instance.
module tb_entrada_dados_fila;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] a_entrada;
  logic        a_in, a_enter, a_sinal, a_full, a_overflow;
  logic [17:0] a_valor;
  logic [2:0]  a_count;
  logic [7:0]  b_entrada;
  logic        b_in, b_enter, b_sinal, b_full, b_overflow;
  logic [7:0]  b_valor;
  logic [3:0]  b_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  entrada_dados_fila dut (
    .clock(clock), .reset(reset), .entrada(a_entrada), .in(a_in), .enter(a_enter),
    .sinal(a_sinal), .valor(a_valor), .count(a_count), .full(a_full), .overflow(a_overflow)
  );

  entrada_dados_fila #(.WIDTH(8), .DEPTH(8), .SYNC_STAGES(3)) dut2 (
    .clock(clock), .reset(reset), .entrada(b_entrada), .in(b_in), .enter(b_enter),
    .sinal(b_sinal), .valor(b_valor), .count(b_count), .full(b_full), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // sel: 0 a_in, 1 a_enter, 2 a_in+a_enter, 3 b_in, 4 b_enter
  task automatic drive(input int sel, input logic v);
    case (sel)
      0: a_in = v;
      1: a_enter = v;
      2: begin a_in = v; a_enter = v; end
      3: b_in = v;
      default: b_enter = v;
    endcase
  endtask

  task automatic press(input int sel);
    drive(sel, 1'b1);
    cyc(4);
    drive(sel, 1'b0);
    cyc(5);
  endtask

  initial begin
    reset = 1'b1; a_entrada = '0; b_entrada = '0;
    a_in = 1'b1; a_enter = 1'b1; b_in = 1'b1; b_enter = 1'b1;
    cyc(3);
    chk("rst_count", a_count, 0);
    chk("rst_sinal", a_sinal, 0);
    chk("rst_valor", a_valor, 0);
    chk("rst_full", a_full, 0);
    chk("rst_ovf", a_overflow, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("hold_count", a_count, 0);
      chk("hold_sinal", a_sinal, 0);
      chk("hold_valor", a_valor, 0);
      chk("hold_ovf", a_overflow, 0);
    end
    chk("hold_b_count", b_count, 0);
    a_in = 1'b0; a_enter = 1'b0; b_in = 1'b0; b_enter = 1'b0;
    cyc(5);

    // single capture, latency N+2
    a_entrada = 18'h2A5F1;
    a_in = 1'b1;
    cyc(2);
    chk("lat_n1_count", a_count, 0);
    cyc(1);
    chk("lat_n2_count", a_count, 1);
    chk("lat_n2_sinal", a_sinal, 1);
    chk("lat_n2_valor", a_valor, 18'h2A5F1);
    cyc(7);
    a_in = 1'b0;
    cyc(5);
    chk("one_push", a_count, 1);
    a_enter = 1'b1;
    cyc(2);
    chk("pop_n1_sinal", a_sinal, 1);
    cyc(1);
    chk("pop_n2_sinal", a_sinal, 0);
    chk("pop_n2_valor", a_valor, 0);
    a_enter = 1'b0;
    cyc(5);

    // fill and overflow
    for (int v = 1; v <= 5; v++) begin
      a_entrada = 18'(v);
      press(0);
    end
    chk("fill_full", a_full, 1);
    chk("fill_count", a_count, 4);
    chk("fill_ovf", a_overflow, 1);
    chk("fill_valor", a_valor, 1);
    for (int k = 2; k <= 4; k++) begin
      press(1);
      chk("drain_valor", a_valor, 32'(k));
    end
    press(1);
    chk("drain_empty_valor", a_valor, 0);
    chk("drain_empty_sinal", a_sinal, 0);
    chk("ovf_sticky", a_overflow, 1);
    press(1);
    chk("pop_empty_count", a_count, 0);
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    chk("ovf_cleared", a_overflow, 0);

    // simultaneous on full
    for (int v = 1; v <= 4; v++) begin
      a_entrada = 18'(v);
      press(0);
    end
    chk("full_before_both", a_full, 1);
    a_entrada = 18'd9;
    press(2);
    chk("both_full_count", a_count, 4);
    chk("both_full_valor", a_valor, 2);
    chk("both_full_ovf", a_overflow, 0);
    for (int k = 0; k < 4; k++) begin
      chk("both_drain", a_valor, (k == 3) ? 32'd9 : 32'(k + 2));
      press(1);
    end
    chk("both_drain_empty", a_sinal, 0);

    // simultaneous on empty
    a_entrada = 18'd7;
    press(2);
    chk("both_empty_count", a_count, 1);
    chk("both_empty_valor", a_valor, 7);
    press(1);
    chk("both_empty_pop", a_count, 0);

    // wrap-around
    for (int i = 0; i < 10; i++) begin
      a_entrada = 18'(32'h10 + i);
      press(0);
      chk("wrap_valor", a_valor, 32'h10 + i);
      press(1);
      chk("wrap_empty", a_sinal, 0);
    end

    // mid-operation reset
    for (int v = 1; v <= 3; v++) begin
      a_entrada = 18'(v + 32'h20);
      press(0);
    end
    chk("pre_rst_count", a_count, 3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_sinal", a_sinal, 0);
    chk("mid_rst_valor", a_valor, 0);
    cyc(5);

    // wide-parameter instance: latency N+3
    b_entrada = 8'hA5;
    b_in = 1'b1;
    cyc(3);
    chk("b_lat_n2_count", b_count, 0);
    cyc(1);
    chk("b_lat_n3_count", b_count, 1);
    chk("b_lat_n3_valor", b_valor, 8'hA5);
    cyc(6);
    b_in = 1'b0;
    cyc(5);
    chk("b_one_push", b_count, 1);
    b_enter = 1'b1;
    cyc(3);
    chk("b_pop_n2_sinal", b_sinal, 1);
    cyc(1);
    chk("b_pop_n3_sinal", b_sinal, 0);
    chk("b_pop_n3_valor", b_valor, 0);
    b_enter = 1'b0;
    cyc(5);

    for (int v = 1; v <= 9; v++) begin
      b_entrada = 8'(v);
      press(3);
      if (v == 7) chk("b_not_full_7", b_full, 0);
      if (v == 8) begin
        chk("b_full_8", b_full, 1);
        chk("b_ovf_8", b_overflow, 0);
      end
    end
    chk("b_count_9", b_count, 8);
    chk("b_ovf_9", b_overflow, 1);
    chk("b_valor_9", b_valor, 1);
    for (int k = 2; k <= 9; k++) begin
      press(4);
      chk("b_drain", b_valor, (k == 9) ? 32'd0 : 32'(k));
    end
    chk("b_drain_sinal", b_sinal, 0);
    chk("b_ovf_sticky", b_overflow, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
